alu_issue_stage: RTL

Decode-and-issue stage that drives the ALU: takes a fetched MIPS instruction plus register-file read data, decodes the ALU operation code, operand selection and destination, and registers everything into the ID/EX pipeline register feeding the ALU's `i_op`, `i_data_a` and `i_data_b` inputs. It sits between the register file and the ALU, and supports pipeline stall, flush and bubble insertion.

---
 rtl/alu_pkg.sv | 97 +++++++++
 rtl/alu_decoder.sv | 60 ++++++
 rtl/alu_issue_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, MIPS opcode/funct constants, decode record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // ALU operation codes, shared with the ALU itself
  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_NOR     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SLL     = 4'd7;
  localparam logic [3:0] ALU_SRA     = 4'd8;
  localparam logic [3:0] ALU_SLA     = 4'd9;
  localparam logic [3:0] ALU_SLT     = 4'd10;
  localparam logic [3:0] ALU_LUI     = 4'd11;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Operand A source: register rs, zero-extended shamt, or constant zero
  typedef enum logic [1:0] {
    ASEL_RS    = 2'd0,
    ASEL_SHAMT = 2'd1,
    ASEL_ZERO  = 2'd2
  } a_sel_t;

  // Operand B source: register rt or extended imm16
  typedef enum logic {
    BSEL_RT  = 1'b0,
    BSEL_IMM = 1'b1
  } b_sel_t;

  // Destination field: rd for R-type, rt for I-type
  typedef enum logic {
    DEST_RD = 1'b0,
    DEST_RT = 1'b1
  } dest_sel_t;

  typedef struct packed {
    logic [3:0] op;
    a_sel_t     a_sel;
    b_sel_t     b_sel;
    logic       ext_sign;
    dest_sel_t  dest_sel;
    logic       legal;
  } dec_t;

  localparam dec_t DEC_NONE = '{
    op:       ALU_ADD,
    a_sel:    ASEL_RS,
    b_sel:    BSEL_RT,
    ext_sign: 1'b0,
    dest_sel: DEST_RD,
    legal:    1'b0
  };

  // I-type decode record: a=rs, b=imm, destination rt
  function automatic dec_t itype(input logic [3:0] op, input logic sext);
    dec_t d;
    d.op       = op;
    d.a_sel    = ASEL_RS;
    d.b_sel    = BSEL_IMM;
    d.ext_sign = sext;
    d.dest_sel = DEST_RT;
    d.legal    = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Instruction decoder: opcode/funct -> ALU op, operand selects, extension, destination.
// Latency: purely combinational.
// Backpressure: none; stateless.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Map opcode (and funct for R-type) onto the decode record; unknowns stay illegal
  always_comb begin
    dec = DEC_NONE;
    case (opcode)
      OPC_RTYPE: begin
        dec.legal    = 1'b1;
        dec.dest_sel = DEST_RD;
        dec.a_sel    = ASEL_RS;
        dec.b_sel    = BSEL_RT;
        case (funct)
          FN_ADD, FN_ADDU: dec.op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.op = ALU_SUB;
          FN_AND:          dec.op = ALU_AND;
          FN_OR:           dec.op = ALU_OR;
          FN_XOR:          dec.op = ALU_XOR;
          FN_NOR:          dec.op = ALU_NOR;
          FN_SLT:          dec.op = ALU_SLT;
          FN_SLL: begin
            dec.op    = ALU_SLL;
            dec.a_sel = ASEL_SHAMT;
          end
          FN_SRL: begin
            dec.op    = ALU_SRL;
            dec.a_sel = ASEL_SHAMT;
          end
          FN_SRA: begin
            dec.op    = ALU_SRA;
            dec.a_sel = ASEL_SHAMT;
          end
          FN_SLLV:         dec.op = ALU_SLL;
          FN_SRLV:         dec.op = ALU_SRL;
          FN_SRAV:         dec.op = ALU_SRA;
          default:         dec.legal = 1'b0;
        endcase
      end
      OPC_ADDI, OPC_ADDIU: dec = itype(ALU_ADD, 1'b1);
      OPC_SLTI:            dec = itype(ALU_SLT, 1'b1);
      OPC_ANDI:            dec = itype(ALU_AND, 1'b0);
      OPC_ORI:             dec = itype(ALU_OR,  1'b0);
      OPC_XORI:            dec = itype(ALU_XOR, 1'b0);
      OPC_LUI: begin
        dec       = itype(ALU_LUI, 1'b0);
        dec.a_sel = ASEL_ZERO;
      end
      default:             dec = DEC_NONE;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: builds ALU op and operands and registers them into ID/EX.
// Latency: 1 cycle, fully registered outputs; optional o_illegal via ALU_ISSUE_ILLEGAL_EN.
// Backpressure: i_stall holds the register (stalled inputs dropped), i_flush loads a bubble.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 4,
  parameter int NB_REG_ADDR  = 5
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [31:0]             i_instr,
  input  logic [NB_DATA-1:0]      i_rs_data,
  input  logic [NB_DATA-1:0]      i_rt_data,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_valid,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic                    o_illegal,
`endif
  output logic [NB_OPERATION-1:0] o_alu_op,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic                    o_reg_wr,
  output logic [NB_REG_ADDR-1:0]  o_wr_addr
);

  // ID/EX register contents; all-zero is the bubble (op ADD == 0)
  typedef struct packed {
    logic                    valid;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                    illegal;
`endif
    logic [NB_OPERATION-1:0] op;
    logic [NB_DATA-1:0]      a;
    logic [NB_DATA-1:0]      b;
    logic                    reg_wr;
    logic [NB_REG_ADDR-1:0]  wr_addr;
  } issue_t;

  localparam issue_t BUBBLE = '0;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         rt_f;
  logic [4:0]         rd_f;
  logic [4:0]         shamt;
  logic [15:0]        imm16;
  logic [NB_DATA-1:0] imm_ext;
  logic [4:0]         dest;
  logic               unused_rs_field;
  dec_t               dec;
  issue_t             issue_d;
  issue_t             issue_q;

  assign opcode = i_instr[31:26];
  assign rt_f   = i_instr[20:16];
  assign rd_f   = i_instr[15:11];
  assign shamt  = i_instr[10:6];
  assign funct  = i_instr[5:0];
  assign imm16  = i_instr[15:0];

  // rs operand arrives pre-read from the register file; the field itself is not needed here
  assign unused_rs_field = ^i_instr[25:21];

  alu_decoder u_alu_decoder (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  assign imm_ext = dec.ext_sign ? {{(NB_DATA-16){imm16[15]}}, imm16}
                                : {{(NB_DATA-16){1'b0}}, imm16};
  assign dest    = (dec.dest_sel == DEST_RD) ? rd_f : rt_f;

  // Build the next ID/EX contents: operand muxes, destination, or bubble/illegal marker
  always_comb begin
    issue_d = BUBBLE;
    if (i_valid && dec.legal) begin
      issue_d.valid   = 1'b1;
      issue_d.op      = NB_OPERATION'(dec.op);
      case (dec.a_sel)
        ASEL_SHAMT: issue_d.a = {{(NB_DATA-5){1'b0}}, shamt};
        ASEL_ZERO:  issue_d.a = '0;
        default:    issue_d.a = i_rs_data;
      endcase
      issue_d.b       = (dec.b_sel == BSEL_IMM) ? imm_ext : i_rt_data;
      issue_d.wr_addr = NB_REG_ADDR'(dest);
      issue_d.reg_wr  = (dest != 5'd0);
    end
`ifdef ALU_ISSUE_ILLEGAL_EN
    else if (i_valid) begin
      issue_d.valid   = 1'b1;
      issue_d.illegal = 1'b1;
      issue_d.op      = NB_OPERATION'(ALU_ILLEGAL);
    end
`endif
  end

  // Pipeline register: reset, then flush, then stall-hold, then normal load
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      issue_q <= BUBBLE;
    end else if (i_flush) begin
      issue_q <= BUBBLE;
    end else if (!i_stall) begin
      issue_q <= issue_d;
    end
  end

  assign o_valid   = issue_q.valid;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign o_illegal = issue_q.illegal;
`endif
  assign o_alu_op  = issue_q.op;
  assign o_data_a  = issue_q.a;
  assign o_data_b  = issue_q.b;
  assign o_reg_wr  = issue_q.reg_wr;
  assign o_wr_addr = issue_q.wr_addr;

endmodule
